// File: rtl/eth_fll_cfg_ctrl.sv
// Boot-time configuration sequencer for the Ethernet 125 MHz FLL: writes two config
// registers, polls the status lock bit with a timeout, then arbitrates software access.
module eth_fll_cfg_ctrl #(
    parameter int AddrWidth     = 2,
    parameter int DataWidth     = 32,
    parameter int LockBit       = 31,
    parameter int PollGap       = 8,
    parameter int TimeoutCycles = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] cfg1_i,
    input  logic [DataWidth-1:0] cfg2_i,
    input  logic                 relock_i,
    output logic                 cfg_req_o,
    input  logic                 cfg_ack_i,
    output logic [AddrWidth-1:0] cfg_addr_o,
    output logic [DataWidth-1:0] cfg_wdata_o,
    output logic                 cfg_we_no,
    input  logic [DataWidth-1:0] cfg_rdata_i,
    input  logic                 sw_req_i,
    input  logic                 sw_we_i,
    input  logic [AddrWidth-1:0] sw_addr_i,
    input  logic [DataWidth-1:0] sw_wdata_i,
    output logic                 sw_gnt_o,
    output logic [DataWidth-1:0] sw_rdata_o,
    output logic                 locked_o,
    output logic                 busy_o,
    output logic                 error_o
);
    localparam int GapW = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(PollGap - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);

    typedef enum logic [2:0] {
        ST_W1, ST_W2, ST_POLL_RD, ST_POLL_GAP, ST_LOCKED, ST_ERROR, ST_SW
    } state_t;

    state_t               r_state, w_state_next;
    logic                 r_req, w_req_next;
    logic [AddrWidth-1:0] r_addr, w_addr_next;
    logic [DataWidth-1:0] r_wdata, w_wdata_next;
    logic                 r_we_n, w_we_n_next;
    logic                 r_gnt, w_gnt_next;
    logic [DataWidth-1:0] r_rdata, w_rdata_next;
    logic                 r_locked, w_locked_next;
    logic                 r_error, w_error_next;
    logic                 r_busy, w_busy_next;
    logic [GapW-1:0]      r_gap_cnt, w_gap_next;
    logic [TmoW-1:0]      r_tmo_cnt, w_tmo_next;
    logic                 r_from_locked, w_from_locked_next;
    logic                 w_timed_out;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= ST_W1;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we_n        <= 1'b1;
            r_gnt         <= 1'b0;
            r_rdata       <= '0;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
            r_gap_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_from_locked <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_req         <= w_req_next;
            r_addr        <= w_addr_next;
            r_wdata       <= w_wdata_next;
            r_we_n        <= w_we_n_next;
            r_gnt         <= w_gnt_next;
            r_rdata       <= w_rdata_next;
            r_locked      <= w_locked_next;
            r_error       <= w_error_next;
            r_busy        <= w_busy_next;
            r_gap_cnt     <= w_gap_next;
            r_tmo_cnt     <= w_tmo_next;
            r_from_locked <= w_from_locked_next;
        end
    end

    assign w_timed_out = (r_tmo_cnt == TmoMax);

    always_comb begin
        w_state_next       = r_state;
        w_req_next         = r_req;
        w_addr_next        = r_addr;
        w_wdata_next       = r_wdata;
        w_we_n_next        = r_we_n;
        w_gnt_next         = 1'b0;
        w_rdata_next       = r_rdata;
        w_gap_next         = r_gap_cnt;
        w_tmo_next         = r_tmo_cnt;
        w_from_locked_next = r_from_locked;

        // A request is only raised when r_req is low, which guarantees the idle cycle after each ack.
        unique case (r_state)
            ST_W1: begin
                if (!r_req) begin
                    w_req_next   = 1'b1;
                    w_addr_next  = AddrWidth'(1);
                    w_wdata_next = cfg1_i;
                    w_we_n_next  = 1'b0;
                end else if (cfg_ack_i) begin
                    w_req_next   = 1'b0;
                    w_state_next = ST_W2;
                end
            end
            ST_W2: begin
                if (!r_req) begin
                    w_req_next   = 1'b1;
                    w_addr_next  = AddrWidth'(2);
                    w_wdata_next = cfg2_i;
                    w_we_n_next  = 1'b0;
                end else if (cfg_ack_i) begin
                    w_req_next   = 1'b0;
                    w_tmo_next   = '0;
                    w_state_next = ST_POLL_RD;
                end
            end
            ST_POLL_RD: begin
                if (!w_timed_out) w_tmo_next = r_tmo_cnt + 1'b1;
                if (!r_req) begin
                    if (w_timed_out) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_req_next  = 1'b1;
                        w_addr_next = '0;
                        w_we_n_next = 1'b1;
                    end
                end else if (cfg_ack_i) begin
                    w_req_next = 1'b0;
                    w_gap_next = '0;
                    // Lock reported on the final read beats the timeout.
                    if (cfg_rdata_i[LockBit])  w_state_next = ST_LOCKED;
                    else if (w_timed_out)      w_state_next = ST_ERROR;
                    else                       w_state_next = ST_POLL_GAP;
                end
            end
            ST_POLL_GAP: begin
                if (!w_timed_out) w_tmo_next = r_tmo_cnt + 1'b1;
                if (w_timed_out)               w_state_next = ST_ERROR;
                else if (r_gap_cnt == GapLast) w_state_next = ST_POLL_RD;
                else                           w_gap_next   = r_gap_cnt + 1'b1;
            end
            ST_LOCKED, ST_ERROR: begin
                // Ignore sw_req_i during the grant cycle so a held request is not served twice.
                if (relock_i) begin
                    w_state_next = ST_W1;
                end else if (sw_req_i && !r_gnt) begin
                    w_state_next       = ST_SW;
                    w_from_locked_next = (r_state == ST_LOCKED);
                    w_addr_next        = sw_addr_i;
                    w_wdata_next       = sw_wdata_i;
                    w_we_n_next        = !sw_we_i;
                end
            end
            ST_SW: begin
                if (!r_req) begin
                    w_req_next = 1'b1;
                end else if (cfg_ack_i) begin
                    w_req_next   = 1'b0;
                    w_gnt_next   = 1'b1;
                    if (r_we_n) w_rdata_next = cfg_rdata_i;
                    w_state_next = r_from_locked ? ST_LOCKED : ST_ERROR;
                end
            end
            default: w_state_next = ST_W1;
        endcase

        w_busy_next   = (w_state_next != ST_LOCKED) && (w_state_next != ST_ERROR);
        w_locked_next = (w_state_next == ST_LOCKED) || ((w_state_next == ST_SW) && w_from_locked_next);
        w_error_next  = (w_state_next == ST_ERROR) || ((w_state_next == ST_SW) && !w_from_locked_next);
    end

    assign cfg_req_o   = r_req;
    assign cfg_addr_o  = r_addr;
    assign cfg_wdata_o = r_wdata;
    assign cfg_we_no   = r_we_n;
    assign sw_gnt_o    = r_gnt;
    assign sw_rdata_o  = r_rdata;
    assign locked_o    = r_locked;
    assign busy_o      = r_busy;
    assign error_o     = r_error;

endmodule

// File: tb/tb_eth_fll_cfg_ctrl.sv
// Bench for eth_fll_cfg_ctrl: an FLL register-file model answers the config port with
// programmable ack latency and lock behaviour; observed transactions are compared to the boot rules.
module tb_eth_fll_cfg_ctrl;
    localparam int AW       = 2;
    localparam int DW       = 32;
    localparam int POLL_GAP = 8;
    localparam int TMO      = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] cfg1_i = '0, cfg2_i = '0;
    logic          relock_i = 1'b0;
    logic          cfg_req_o, cfg_we_no;
    logic          cfg_ack_i = 1'b0;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_wdata_o;
    logic [DW-1:0] cfg_rdata_i = '0;
    logic          sw_req_i = 1'b0, sw_we_i = 1'b0;
    logic [AW-1:0] sw_addr_i = '0;
    logic [DW-1:0] sw_wdata_i = '0;
    logic          sw_gnt_o;
    logic [DW-1:0] sw_rdata_o;
    logic          locked_o, busy_o, error_o;

    eth_fll_cfg_ctrl #(
        .AddrWidth(AW), .DataWidth(DW), .LockBit(31), .PollGap(POLL_GAP), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg1_i(cfg1_i), .cfg2_i(cfg2_i), .relock_i(relock_i),
        .cfg_req_o(cfg_req_o), .cfg_ack_i(cfg_ack_i), .cfg_addr_o(cfg_addr_o),
        .cfg_wdata_o(cfg_wdata_o), .cfg_we_no(cfg_we_no), .cfg_rdata_i(cfg_rdata_i),
        .sw_req_i(sw_req_i), .sw_we_i(sw_we_i), .sw_addr_i(sw_addr_i), .sw_wdata_i(sw_wdata_i),
        .sw_gnt_o(sw_gnt_o), .sw_rdata_o(sw_rdata_o),
        .locked_o(locked_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // FLL model state
    typedef struct {
        logic [AW-1:0] addr;
        logic          we_n;
        logic [DW-1:0] wdata;
        int            cyc;
    } txn_t;
    txn_t          log_q[$];
    int            ack_delay = 2;
    int            lock_after = 3;
    int            poll_reads = 0;
    bit            sw_mode = 1'b0;
    bit            stall_w2 = 1'b0;
    logic [DW-1:0] sw_status = '0;
    logic [DW-1:0] fll_regs [4];
    int            w2_ack_cyc = 0;

    initial begin : responder
        int            wcnt;
        logic [AW-1:0] c_addr;
        logic          c_we_n;
        logic [DW-1:0] c_wdata;
        int            c_cyc;
        logic [DW-1:0] rd;
        wcnt = 0;
        c_addr = '0; c_we_n = 1'b1; c_wdata = '0; c_cyc = 0;
        for (int i = 0; i < 4; i++) fll_regs[i] = '0;
        forever begin
            @(negedge clk);
            if (cfg_ack_i) begin
                cfg_ack_i   = 1'b0;
                cfg_rdata_i = $urandom;
                chk("req_drop_after_ack", 32'(cfg_req_o), 0);
                wcnt = 0;
            end else if (cfg_req_o) begin
                if (wcnt == 0) begin
                    c_addr = cfg_addr_o; c_we_n = cfg_we_no; c_wdata = cfg_wdata_o; c_cyc = cyc;
                end else begin
                    chk("hold_addr", 32'(cfg_addr_o), 32'(c_addr));
                    chk("hold_we_n", 32'(cfg_we_no), 32'(c_we_n));
                    chk("hold_wdata", cfg_wdata_o, c_wdata);
                end
                if (wcnt >= ack_delay && !(stall_w2 && c_addr == 2)) begin
                    if (!c_we_n) begin
                        fll_regs[c_addr] = c_wdata;
                        rd = $urandom;
                        if (c_addr == 2) w2_ack_cyc = cyc;
                    end else if (c_addr == 0) begin
                        if (sw_mode) begin
                            rd = sw_status;
                        end else begin
                            poll_reads++;
                            rd = {(lock_after != 0 && poll_reads >= lock_after), 31'($urandom)};
                        end
                    end else begin
                        rd = fll_regs[c_addr];
                    end
                    cfg_ack_i   = 1'b1;
                    cfg_rdata_i = rd;
                    log_q.push_back('{addr: c_addr, we_n: c_we_n, wdata: c_wdata, cyc: c_cyc});
                    $display("txn @%0d: addr=%0d we_n=%0b wdata=%h rdata=%h", cyc, c_addr, c_we_n, c_wdata, rd);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(cfg_req_o), 0);
        chk({tag, "_we_n"}, 32'(cfg_we_no), 1);
        chk({tag, "_addr"}, 32'(cfg_addr_o), 0);
        chk({tag, "_wdata"}, cfg_wdata_o, 0);
        chk({tag, "_gnt"}, 32'(sw_gnt_o), 0);
        chk({tag, "_rdata"}, sw_rdata_o, 0);
        chk({tag, "_locked"}, 32'(locked_o), 0);
        chk({tag, "_error"}, 32'(error_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic prep_boot(input int d, input int nl);
        ack_delay  = d;
        lock_after = nl;
        poll_reads = 0;
        sw_mode    = 1'b0;
        log_q.delete();
        cfg1_i = $urandom;
        cfg2_i = $urandom;
    endtask

    task automatic pulse_relock();
        relock_i = 1'b1;
        @(negedge clk);
        relock_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_reached"}, 32'(busy_o), 0);
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        while (!sw_gnt_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_gnt_seen"}, 32'(sw_gnt_o), 1);
    endtask

    task automatic check_boot(input string tag, input int nlock);
        chk({tag, "_ntxn"}, 32'(log_q.size()), 32'(2 + nlock));
        if (log_q.size() >= 2) begin
            chk({tag, "_w1_addr"}, 32'(log_q[0].addr), 1);
            chk({tag, "_w1_we_n"}, 32'(log_q[0].we_n), 0);
            chk({tag, "_w1_data"}, log_q[0].wdata, cfg1_i);
            chk({tag, "_w2_addr"}, 32'(log_q[1].addr), 2);
            chk({tag, "_w2_we_n"}, 32'(log_q[1].we_n), 0);
            chk({tag, "_w2_data"}, log_q[1].wdata, cfg2_i);
        end
        for (int i = 2; i < log_q.size(); i++) begin
            chk($sformatf("%s_rd%0d_addr", tag, i - 1), 32'(log_q[i].addr), 0);
            chk($sformatf("%s_rd%0d_we_n", tag, i - 1), 32'(log_q[i].we_n), 1);
            if (i > 2)
                chk($sformatf("%s_rd%0d_gap_ok", tag, i - 1),
                    32'(log_q[i].cyc - log_q[i-1].cyc >= POLL_GAP), 1);
        end
        chk({tag, "_locked"}, 32'(locked_o), 1);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_error"}, 32'(error_o), 0);
    endtask

    // One software access from an idle state; sw_* inputs are scrambled after entry to
    // confirm the access uses the values present when it was accepted.
    task automatic sw_access(input string tag, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [DW-1:0] exp_rd,
                             input logic exp_lk, input logic exp_er);
        log_q.delete();
        sw_mode   = 1'b1;
        sw_req_i  = 1'b1;
        sw_we_i   = we;
        sw_addr_i = addr;
        sw_wdata_i = data;
        @(negedge clk);
        sw_we_i    = ~we;
        sw_addr_i  = AW'($urandom);
        sw_wdata_i = $urandom;
        wait_gnt(tag);
        sw_req_i = 1'b0;
        chk({tag, "_ntxn"}, 32'(log_q.size()), 1);
        if (log_q.size() == 1) begin
            chk({tag, "_addr"}, 32'(log_q[0].addr), 32'(addr));
            chk({tag, "_we_n"}, 32'(log_q[0].we_n), 32'(!we));
            if (we) chk({tag, "_wdata"}, log_q[0].wdata, data);
        end
        if (!we) chk({tag, "_rdata"}, sw_rdata_o, exp_rd);
        chk({tag, "_locked"}, 32'(locked_o), 32'(exp_lk));
        chk({tag, "_error"}, 32'(error_o), 32'(exp_er));
        chk({tag, "_busy"}, 32'(busy_o), 0);
        @(negedge clk);
        chk({tag, "_gnt_pulse"}, 32'(sw_gnt_o), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_no_extra_req"}, 32'(log_q.size()), 1);
        sw_mode = 1'b0;
    endtask

    initial begin : main
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int n;
        int err_cyc;
        int snap;

        repeat (4) @(negedge clk);
        check_reset_vals("rst");

        // Reset boot: ack after 2 cycles, lock on the 3rd status read
        prep_boot(2, 3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(cfg_req_o), 1);
        chk("first_addr", 32'(cfg_addr_o), 1);
        wait_idle("boot0");
        check_boot("boot0", 3);

        sw_status = 32'h8000_0005;
        sw_access("sw_rd0", 1'b0, 2'd0, '0, 32'h8000_0005, 1'b1, 1'b0);
        sw_access("sw_wr3", 1'b1, 2'd3, 32'hDEAD_BEEF, '0, 1'b1, 1'b0);
        sw_access("sw_rd3", 1'b0, 2'd3, '0, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // relock and sw_req together: boot first, then the software read of addr 1
        prep_boot(1, 2);
        relock_i = 1'b1; sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = 2'd1; sw_wdata_i = '0;
        @(negedge clk);
        relock_i = 1'b0;
        chk("relock_clr_locked", 32'(locked_o), 0);
        chk("relock_busy", 32'(busy_o), 1);
        wait_gnt("relock_sw");
        sw_req_i = 1'b0;
        chk("relock_sw_ntxn", 32'(log_q.size()), 5);
        if (log_q.size() == 5) begin
            chk("relock_sw_first_addr", 32'(log_q[0].addr), 1);
            chk("relock_sw_last_addr", 32'(log_q[4].addr), 1);
            chk("relock_sw_last_we_n", 32'(log_q[4].we_n), 1);
        end
        chk("relock_sw_rdata", sw_rdata_o, cfg1_i);
        chk("relock_sw_locked", 32'(locked_o), 1);
        @(negedge clk);
        chk("relock_sw_gnt_pulse", 32'(sw_gnt_o), 0);
        repeat (3) @(negedge clk);

        // Randomized boots with ignored mid-sequence relocks, then a sw write/read pair
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            prep_boot($urandom_range(0, 3), n);
            pulse_relock();
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if (busy_o) pulse_relock();
            wait_idle($sformatf("rboot%0d", it));
            check_boot($sformatf("rboot%0d", it), n);
            a = AW'($urandom_range(1, 3));
            d = $urandom;
            sw_access($sformatf("rsw_wr%0d", it), 1'b1, a, d, '0, 1'b1, 1'b0);
            sw_access($sformatf("rsw_rd%0d", it), 1'b0, a, '0, d, 1'b1, 1'b0);
        end

        // Status never locks: timeout to ERROR, then silence on the port
        prep_boot(2, 0);
        pulse_relock();
        n = 0;
        while (!error_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        chk("tmo_error", 32'(error_o), 1);
        chk("tmo_locked", 32'(locked_o), 0);
        chk("tmo_busy", 32'(busy_o), 0);
        chk("tmo_not_early", 32'(err_cyc - w2_ack_cyc >= TMO), 1);
        chk("tmo_not_late", 32'(err_cyc - w2_ack_cyc <= TMO + POLL_GAP + 8), 1);
        snap = log_q.size();
        repeat (40) @(negedge clk);
        chk("tmo_no_more_req", 32'(log_q.size()), 32'(snap));
        chk("tmo_req_low", 32'(cfg_req_o), 0);
        sw_access("err_sw_rd2", 1'b0, 2'd2, '0, cfg2_i, 1'b0, 1'b1);

        // relock from ERROR restarts at addr 1
        prep_boot(1, 2);
        pulse_relock();
        chk("err_relock_clr", 32'(error_o), 0);
        wait_idle("err_relock");
        check_boot("err_relock", 2);

        // Reset while the addr 2 write is outstanding
        prep_boot(1, 1);
        stall_w2 = 1'b1;
        pulse_relock();
        n = 0;
        while (!(cfg_req_o && cfg_addr_o == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_w2_pending", 32'(cfg_req_o && cfg_addr_o == 2), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        @(negedge clk);
        stall_w2 = 1'b0;
        prep_boot(1, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_first_req", 32'(cfg_req_o), 1);
        chk("midrst_first_addr", 32'(cfg_addr_o), 1);
        wait_idle("midrst_boot");
        check_boot("midrst_boot", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_fll_cfg_ctrl.md
# eth_fll_cfg_ctrl

Configuration sequencer for the Ethernet 125 MHz clock FLL. After reset it programs the FLL through its request/acknowledge configuration port and polls the status register until lock or timeout. Once the sequence finishes, it gives a single software requester access to the same port. It sits between the SoC register bus and the FLL inside the Ethernet clock generation subsystem.

## Interface
- AddrWidth, 2: width of the FLL config address.
- DataWidth, 32: width of the FLL config data.
- LockBit, 31: bit index of the lock flag in status register (addr 0).
- PollGap, 8: idle cycles between consecutive status reads.
- TimeoutCycles, 4096: maximum cycles in polling before the error is declared.

Ports:
- clk_i  in  1  block clock; one clock domain only.
- rst_ni  in  1  reset; synchronous, active-low.
- cfg1_i  in  DataWidth  boot value for FLL register 1; sampled at each write.
- cfg2_i  in  DataWidth  boot value for FLL register 2; sampled at each write.
- relock_i  in  1  pulse; restarts the boot sequence from an idle state.
- cfg_req_o  out  1  FLL config request.
- cfg_ack_i  in  1  FLL config acknowledge.
- cfg_addr_o  out  AddrWidth  FLL config address.
- cfg_wdata_o  out  DataWidth  FLL config write data.
- cfg_we_no  out  1  FLL write enable, active-low.
- cfg_rdata_i  in  DataWidth  FLL read data; valid in the ack cycle.
- sw_req_i, sw_we_i, sw_addr_i[AddrWidth], sw_wdata_i[DataWidth]  in  software access request.
- sw_gnt_o  out  1  one-cycle pulse; software access completed.
- sw_rdata_o  out  DataWidth  read data; valid with sw_gnt_o when the access is a read.
- locked_o, busy_o, error_o  out  1 each  status flags.

## Operation
- States: W1, W2, POLL_RD, POLL_GAP, LOCKED, ERROR, SW.
- After reset: enter W1.
- W1: write cfg1_i to addr 1. On ack, go to W2.
- W2: write cfg2_i to addr 2. On ack, go to POLL_RD.
- POLL_RD: read addr 0. On ack:
  - If cfg_rdata_i[LockBit] = 1, go to LOCKED.
  - Otherwise go to POLL_GAP.
- POLL_GAP: wait PollGap cycles, then return to POLL_RD.
- Timeout counter:
  - Clears on entry to POLL_RD from W2.
  - Increments every cycle in POLL_RD and POLL_GAP; saturates.
  - Reaching TimeoutCycles with no lock sends the FSM to ERROR. The timeout takes effect only outside a pending request; an outstanding read first completes.
  - A lock seen on that final ack wins over the timeout.
- LOCKED and ERROR are the idle states:
  - relock_i: go to W1 and clear locked_o and error_o.
  - Else sw_req_i: go to SW.
  - relock_i has priority over sw_req_i arriving in the same cycle. The software request stays pending and is served after the new sequence finishes.
- SW:
  - Drive sw_addr_i, sw_wdata_i and cfg_we_no = !sw_we_i, all captured on entry.
  - On ack: pulse sw_gnt_o. For reads, drive sw_rdata_o = cfg_rdata_i.
  - Then return to the idle state the FSM came from.
- sw_req_i in any non-idle state is stalled; sw_gnt_o stays 0.
- relock_i outside the idle states is ignored.
- Flags:
  - busy_o = 1 in W1, W2, POLL_RD, POLL_GAP and SW.
  - locked_o = 1 in LOCKED, and in SW entered from LOCKED.
  - error_o = 1 in ERROR, and in SW entered from ERROR.

## Timing
- Reset values:
  - cfg_req_o = 0, cfg_we_no = 1, cfg_addr_o = 0, cfg_wdata_o = 0.
  - sw_gnt_o = 0, sw_rdata_o = 0.
  - locked_o = 0, error_o = 0, busy_o = 0.
  - The first request is raised in the cycle after rst_ni is released.
- All outputs are registered.
- Handshake:
  - cfg_req_o stays high, with address, data and write enable stable, until the cycle in which cfg_ack_i = 1.
  - cfg_req_o is low in the cycle after the ack.
  - A new request starts no earlier than 1 cycle later, so there is at least 1 idle cycle between requests.
  - cfg_ack_i while cfg_req_o = 0 is ignored.
- sw_gnt_o and sw_rdata_o are registered 1 cycle after the ack cycle.
- rst_ni low mid-transaction: return to reset values in the next cycle, even if a request is outstanding. No pending access is replayed.

## Test plan
- Boot, ack after 2 cycles, lock on the 3rd status read:
  - Required: writes to addr 1 then addr 2 carrying the cfg1_i and cfg2_i values, with cfg_we_no = 0.
  - Then 3 reads of addr 0, spaced at least PollGap apart.
  - locked_o = 1, busy_o = 0.
- Status never locks, with TimeoutCycles = 64:
  - Required: error_o = 1 and no further requests.
  - relock_i restarts the sequence at addr 1.
- After lock, software read of addr 0 with the FLL returning 32'h8000_0005:
  - Required: one request, then sw_gnt_o pulse with sw_rdata_o = 32'h8000_0005.
  - The FSM returns to LOCKED.
- Software write of addr 3 = 32'hDEAD_BEEF after lock:
  - Required: cfg_we_no = 0 and cfg_addr_o = 3 until ack, then sw_gnt_o.
- relock_i and sw_req_i in the same cycle while LOCKED:
  - Required: the boot sequence runs first, with sw_gnt_o = 0 throughout.
  - The software access is granted after relock completes.
- rst_ni asserted while the addr 2 write is pending with no ack:
  - Required: cfg_req_o = 0 in the next cycle and all outputs at reset values.
  - After release, the sequence restarts at addr 1.
